// File: rtl/path_sequencer.sv
// path_sequencer: snapshots nine captured path words on a path_found rise,
// validates them, then streams node IDs to the navigation controller over a
// valid/ready handshake and pulses done once the path has been consumed.
// Optional feature macro: PATH_SEQ_RETURN_EN adds a return pass
// (len-2 down to 0) after the forward pass, flagged with node_rev.
module path_sequencer #(
  parameter int          NODE_W   = 5,
  parameter logic [31:0] END_MARK = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       path0,
  input  logic [31:0]       path1,
  input  logic [31:0]       path2,
  input  logic [31:0]       path3,
  input  logic [31:0]       path4,
  input  logic [31:0]       path5,
  input  logic [31:0]       path6,
  input  logic [31:0]       path7,
  input  logic [31:0]       path8,
  input  logic              path_found,
  input  logic              abort,
  input  logic              node_ready,
  output logic              node_valid,
  output logic [NODE_W-1:0] node_id,
  output logic [3:0]        node_idx,
  output logic              node_last,
  output logic              node_rev,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EMIT   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              pf_q;
  logic [NODE_W-1:0] buf_q [9];
  logic [NODE_W-1:0] buf_d [9];
  logic [3:0]        len_q, len_d;
  logic [3:0]        idx_q, idx_d;
  logic              rev_q, rev_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

  logic [31:0]       path_in [9];
  logic [3:0]        load_len;
  logic              load_bad;
  logic              start;
  logic              is_last;

  assign path_in[0] = path0;
  assign path_in[1] = path1;
  assign path_in[2] = path2;
  assign path_in[3] = path3;
  assign path_in[4] = path4;
  assign path_in[5] = path5;
  assign path_in[6] = path6;
  assign path_in[7] = path7;
  assign path_in[8] = path8;

  assign start = path_found & ~pf_q;

  // Path length (first END_MARK index) and validity of the words before it.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    load_len = 4'd9;
    load_bad = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      if (path_in[i] == END_MARK) load_len = 4'(i);
    end
    for (int i = 0; i < 9; i++) begin
      if ((4'(i) < load_len) && (|path_in[i][31:NODE_W])) load_bad = 1'b1;
    end
    if (load_len == 4'd0) load_bad = 1'b1;
  end

  // The node currently presented is the final handshake of the path.
  always_comb begin
`ifdef PATH_SEQ_RETURN_EN
    is_last = (rev_q && (idx_q == 4'd0)) || (!rev_q && (len_q == 4'd1));
`else
    is_last = (idx_q == (len_q - 4'd1));
`endif
  end

  // Next-state logic: load/reject, index walk, finish pulse, abort.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rev_d   = rev_q;
    err_d   = err_q;
    ovr_d   = ovr_q;

    if (abort) begin
      // abort wins over a same-cycle handshake and over start
      state_d = S_IDLE;
      idx_d   = 4'd0;
      rev_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (load_bad) begin
              err_d = 1'b1;
            end else begin
              for (int i = 0; i < 9; i++) buf_d[i] = path_in[i][NODE_W-1:0];
              len_d   = load_len;
              idx_d   = 4'd0;
              rev_d   = 1'b0;
              err_d   = 1'b0;
              ovr_d   = 1'b0;
              state_d = S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (start) ovr_d = 1'b1;
          if (node_ready) begin
            if (is_last) begin
              state_d = S_FINISH;
            end else if (rev_q) begin
              idx_d = idx_q - 4'd1;
`ifdef PATH_SEQ_RETURN_EN
            end else if (idx_q == (len_q - 4'd1)) begin
              // forward pass exhausted: turn around, skipping the far end
              rev_d = 1'b1;
              idx_d = len_q - 4'd2;
`endif
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        S_FINISH: begin
          if (start) ovr_d = 1'b1;
          state_d = S_IDLE;
          idx_d   = 4'd0;
          rev_d   = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
          rev_d   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the nine-entry buffer is reset with everything else because
      // its power-on contents must read as zero; it is small enough for
      // plain flops.
      state_q <= S_IDLE;
      pf_q    <= 1'b0;
      for (int i = 0; i < 9; i++) buf_q[i] <= '0;
      len_q   <= 4'd0;
      idx_q   <= 4'd0;
      rev_q   <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      pf_q    <= path_found;
      buf_q   <= buf_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rev_q   <= rev_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // Outputs decoded from state; node fields read zero when nothing is offered.
  // Without the return pass rev_q never leaves 0, so node_rev stays 0.
  always_comb begin
    node_valid = (state_q == S_EMIT);
    node_id    = node_valid ? buf_q[idx_q] : '0;
    node_idx   = node_valid ? idx_q : 4'd0;
    node_last  = node_valid & is_last;
    node_rev   = node_valid & rev_q;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_FINISH);
    err        = err_q;
    overrun    = ovr_q;
  end

endmodule

// File: doc/path_sequencer.md
# path_sequencer

Downstream consumer of the path-capture stage. Snapshots the nine captured path words (`path0`..`path8`) when the CPU signals `path_found`, and validates them. It then hands node IDs one at a time to the motion/navigation controller over a valid/ready handshake. Emits a one-cycle `done` pulse when the path has been fully consumed.

## Interface

Parameters:
- `NODE_W`, 5: width of a node ID; the low `NODE_W` bits of a path word.
- `END_MARK`, 32'hFFFF_FFFF: terminator word; it and all later entries are ignored.

Ports:
- `clk` in 1: single clock, posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `path0`..`path8` in 32 each: captured path words, updated by the upstream stage on negedge `clk`.
- `path_found` in 1: upstream "path complete" flag.
- `abort` in 1: synchronous return to IDLE.
- `node_ready` in 1: consumer accepts the current node.
- `node_valid` out 1: `node_id` is valid.
- `node_id` out `NODE_W`: current node.
- `node_idx` out 4: index (0..8) of the current entry in the buffer.
- `node_last` out 1: current node is the final one to be emitted.
- `node_rev` out 1: current node belongs to the return pass.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse after the final handshake.
- `err` out 1: sticky; last load was rejected.
- `overrun` out 1: sticky; a `path_found` rise occurred while busy.

## Operation

- States: IDLE, EMIT, FINISH.
- `pf_q` registers `path_found`. `start` = `path_found & ~pf_q`.
- Length `len` is the index of the first word equal to `END_MARK`, or 9 if there is none.
- IDLE, on `start`:
  - Reject the load if any word before `len` has nonzero bits above `NODE_W`, or if `len` is 0. On reject: `err`=1, stay in IDLE, buffer unchanged.
  - Otherwise: copy all nine words to the internal buffer, latch `len`, set `idx`=0, clear `err` and `overrun`, go to EMIT.
- EMIT:
  - `node_valid`=1; `node_id` = `buf[idx][NODE_W-1:0]`.
  - On `node_valid & node_ready`: if this is the last node, go to FINISH; otherwise advance `idx` (+1 on the forward pass).
- FINISH: `done`=1 for exactly one cycle, then go to IDLE.
- `start` while in EMIT or FINISH: ignored, buffer untouched, `overrun`=1.
- `abort` (any state): next state is IDLE, `idx`=0, no `done` pulse. `abort` has priority over a same-cycle handshake and over `start`.
- Buffer contents are never re-read from the `path*` inputs after the snapshot. Upstream changes during EMIT have no effect.

## Timing

- Reset values: state IDLE, `node_valid`/`node_last`/`node_rev`/`busy`/`done`/`err`/`overrun`/`pf_q` = 0, `node_id`/`node_idx` = 0, buffer = 0.
- Inputs change on negedge and are sampled on posedge, giving half a cycle of setup.
- `start` sampled at posedge k → `node_valid`=1 and `busy`=1 from cycle k+1 onward.
- While `node_valid`=1, `node_id`/`node_idx`/`node_last`/`node_rev` hold stable until the handshake.
- Handshake at posedge m → the next node is presented in cycle m+1 (zero bubbles); `node_ready` may be held high continuously.
- Final handshake at m → `node_valid`=0 and `done`=1 in cycle m+1; IDLE in cycle m+2, where a new `start` is accepted.
- A `path_found` level held high produces only one `start`.

## Configuration

- `PATH_SEQ_RETURN_EN` defined:
  - After the forward pass (indices 0..`len`-1), emit a return pass with indices `len`-2 down to 0, with `node_rev`=1.
  - `node_last` is asserted only on index 0 of the return pass.
  - If `len`=1, there is no return pass.
  - Total handshakes = 2·`len`-1.
- `PATH_SEQ_RETURN_EN` not defined:
  - Forward pass only; `node_last` is asserted at `idx`=`len`-1.
  - `node_rev` is tied to 0.

## Test plan

- Load 3, 7, 12, `END_MARK`, … with a `path_found` rise and `node_ready`=1 constantly → `node_valid` rises 1 cycle after `start`. `node_id` sequence is 3, 7, 12, with `node_last` on 12. `done` pulses 1 cycle later. With the macro: sequence is 3, 7, 12, 7, 3, with `node_rev`=1 on the last two and `node_last` on the final 3.
- All nine words valid (0..8) with `node_ready` toggling every other cycle → nine handshakes. `node_id` is held during stalls. `node_idx` goes 0..8.
- `path2`=32'h0000_0040 (bit above `NODE_W` set) → `err`=1, `busy` stays 0, no `node_valid`.
- `path0`=`END_MARK` → `err`=1, no emission.
- Second `path_found` rise at `idx`=2 with different path words → `overrun`=1 and the original sequence completes unchanged.
- `abort` at `idx`=1, in the same cycle as `node_ready` → next cycle IDLE, `node_valid`=0, no `done` pulse. Then `reset_n` low mid-EMIT → all outputs return to 0 immediately (asynchronous).
